// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS sequencing controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_WB_MEM    = 4'd6,
      S_EXEC_R    = 4'd7,
      S_EXEC_I    = 4'd8,
      S_WB_ALU    = 4'd9,
      S_BRANCH    = 4'd10
   } state_t;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLTU = 6'b101011;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'b000,
      ALU_SUB  = 3'b001,
      ALU_AND  = 3'b010,
      ALU_OR   = 3'b011,
      ALU_SLL  = 3'b100,
      ALU_SRL  = 3'b101,
      ALU_SLT  = 3'b110,
      ALU_SLTU = 3'b111
   } alu_op_t;

   // ALU B-input mux selects
   localparam logic [1:0] SRC_B_REG      = 2'b00;
   localparam logic [1:0] SRC_B_FOUR     = 2'b01;
   localparam logic [1:0] SRC_B_IMM      = 2'b10;
   localparam logic [1:0] SRC_B_IMM_SHL2 = 2'b11;

endpackage

// File: rtl/multicycle_control_alu_func_decode.sv
// R-type func field decoder: maps func to an ALU operation and a legality flag.
// Latency: purely combinational.
// Backpressure: none.
// Ports: func (in, IR[5:0]); alu_op (out, ALU operation); legal (out, func is supported).
module alu_func_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] func,
   output alu_op_t    alu_op,
   output logic       legal
);

   always_comb begin
      alu_op = ALU_ADD;
      legal  = 1'b1;
      case (func)
         FN_ADD, FN_ADDU: alu_op = ALU_ADD;
         FN_SUB, FN_SUBU: alu_op = ALU_SUB;
         FN_AND:          alu_op = ALU_AND;
         FN_OR:           alu_op = ALU_OR;
         FN_SLL:          alu_op = ALU_SLL;
         FN_SRL:          alu_op = ALU_SRL;
         FN_SLT:          alu_op = ALU_SLT;
         FN_SLTU:         alu_op = ALU_SLTU;
         default:         legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Moore-style multi-cycle sequencer for the MIPS datapath (fetch/decode/exec/mem/wb).
// Latency: 3-5 cycles per instruction with zero-wait memory, +1 per memory wait cycle.
// Backpressure: FETCH/MEM_READ/MEM_WRITE hold with request stable until mem_ready.
// Ports: clk, rst_n; op_code/func (IR fields, valid from DECODE); zero (ALU flag);
//        mem_ready (memory handshake); datapath controls (mem_req ... alu_op);
//        illegal_instr (pulse in DECODE); state (debug view of current state).
module multicycle_control
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op_code,
   input  logic [5:0] func,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_src,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic       illegal_instr,
   output logic [3:0] state
);

   state_t  state_q;
   state_t  state_d;
   alu_op_t func_op;
   logic    func_legal;

   alu_func_decode u_func_decode (
      .func   (func),
      .alu_op (func_op),
      .legal  (func_legal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_src        = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRC_B_REG;
      alu_op        = ALU_ADD;
      illegal_instr = 1'b0;

      case (state_q)
         S_IDLE: state_d = S_FETCH;

         // PC+4 is computed alongside the fetch and committed with the IR.
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRC_B_FOUR;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end

         // Branch target is computed speculatively into ALUOut here.
         S_DECODE: begin
            alu_src_b = SRC_B_IMM_SHL2;
            case (op_code)
               OP_LW, OP_SW:      state_d = S_MEM_ADDR;
               OP_ADDI, OP_ADDIU: state_d = S_EXEC_I;
               OP_BEQ:            state_d = S_BRANCH;
               OP_RTYPE: begin
                  if (func_legal) begin
                     state_d = S_EXEC_R;
                  end else begin
                     illegal_instr = 1'b1;
                     state_d       = S_FETCH;
                  end
               end
               default: begin
                  illegal_instr = 1'b1;
                  state_d       = S_FETCH;
               end
            endcase
         end

         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRC_B_IMM;
            state_d   = (op_code == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         end

         S_MEM_READ: begin
            mem_req = 1'b1;
            i_or_d  = 1'b1;
            if (mem_ready) state_d = S_WB_MEM;
         end

         S_MEM_WRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            i_or_d  = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end

         S_WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = S_FETCH;
         end

         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = func_op;
            state_d   = S_WB_ALU;
         end

         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = SRC_B_IMM;
            state_d   = S_WB_ALU;
         end

         // IR is still held, so the opcode selects rd vs rt here.
         S_WB_ALU: begin
            reg_write = 1'b1;
            reg_dst   = (op_code == OP_RTYPE);
            state_d   = S_FETCH;
         end

         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = 1'b1;
            pc_write  = zero;
            state_d   = S_FETCH;
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control with hand-written reset corner cases.
module tb_multicycle_control;
   import mc_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op_code, func;
   logic       zero, mem_ready;
   logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src;
   logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_op;
   logic       illegal_instr;
   logic [3:0] state;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .op_code(op_code), .func(func), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .illegal_instr(illegal_instr), .state(state)
   );

   // Control word layout:
   // [15] mem_req [14] mem_we [13] i_or_d [12] ir_write [11] pc_write [10] pc_src
   // [9] reg_write [8] reg_dst [7] mem_to_reg [6] alu_src_a [5:4] alu_src_b
   // [3:1] alu_op [0] illegal_instr
   localparam logic [15:0] C_IDLE      = 16'h0000;
   localparam logic [15:0] C_FETCH_W   = 16'h8010;
   localparam logic [15:0] C_FETCH     = 16'h9810;
   localparam logic [15:0] C_DECODE    = 16'h0030;
   localparam logic [15:0] C_DEC_ILL   = 16'h0031;
   localparam logic [15:0] C_MEM_ADDR  = 16'h0060;
   localparam logic [15:0] C_MEM_READ  = 16'hA000;
   localparam logic [15:0] C_MEM_WRITE = 16'hE000;
   localparam logic [15:0] C_WB_MEM    = 16'h0280;
   localparam logic [15:0] C_EX_ADD    = 16'h0040;
   localparam logic [15:0] C_EX_SUB    = 16'h0042;
   localparam logic [15:0] C_EX_SLL    = 16'h0048;
   localparam logic [15:0] C_EX_SLTU   = 16'h004E;
   localparam logic [15:0] C_EXEC_I    = 16'h0060;
   localparam logic [15:0] C_WB_R      = 16'h0300;
   localparam logic [15:0] C_WB_I      = 16'h0200;
   localparam logic [15:0] C_BR_TAKEN  = 16'h0C42;
   localparam logic [15:0] C_BR_NOT    = 16'h0442;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      logic       rdy;
      state_t     st;
      logic [15:0] cw;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [15:0] obs_cw();
      return {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, reg_write,
              reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_instr};
   endfunction

   task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic rdy, input state_t st, input logic [15:0] cw);
      vec_t v;
      v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.st = st; v.cw = cw;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [3:0] st_exp, input logic [15:0] cw_exp);
      logic [15:0] cw_act;
      cw_act = obs_cw();
      checks++;
      if (state !== st_exp) begin
         errors++;
         $display("FAIL %s state: got %0d expected %0d", name, state, st_exp);
      end
      checks++;
      if (cw_act !== cw_exp) begin
         errors++;
         $display("FAIL %s controls: got %h expected %h", name, cw_act, cw_exp);
      end
   endtask

   // Inputs are driven just after the rising edge; outputs sampled on the falling edge.
   task automatic step(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input state_t st, input logic [15:0] cw);
      op_code = op; func = fn; zero = z; mem_ready = rdy;
      @(negedge clk);
      check(name, st, cw);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; op_code = 6'd0; func = 6'd0; zero = 1'b0; mem_ready = 1'b1;

      // Table: one entry per cycle, starting with the first cycle after reset release.
      add(OP_RTYPE, FN_ADD, 0, 1, S_IDLE,     C_IDLE);
      // ADD
      add(OP_RTYPE, FN_ADD, 0, 1, S_FETCH,    C_FETCH);
      add(OP_RTYPE, FN_ADD, 0, 1, S_DECODE,   C_DECODE);
      add(OP_RTYPE, FN_ADD, 0, 1, S_EXEC_R,   C_EX_ADD);
      add(OP_RTYPE, FN_ADD, 0, 1, S_WB_ALU,   C_WB_R);
      // SUBU
      add(OP_RTYPE, FN_SUBU, 0, 1, S_FETCH,   C_FETCH);
      add(OP_RTYPE, FN_SUBU, 0, 1, S_DECODE,  C_DECODE);
      add(OP_RTYPE, FN_SUBU, 0, 1, S_EXEC_R,  C_EX_SUB);
      add(OP_RTYPE, FN_SUBU, 0, 1, S_WB_ALU,  C_WB_R);
      // SLL (func 000000)
      add(OP_RTYPE, FN_SLL, 0, 1, S_FETCH,    C_FETCH);
      add(OP_RTYPE, FN_SLL, 0, 1, S_DECODE,   C_DECODE);
      add(OP_RTYPE, FN_SLL, 0, 1, S_EXEC_R,   C_EX_SLL);
      add(OP_RTYPE, FN_SLL, 0, 1, S_WB_ALU,   C_WB_R);
      // SLTU
      add(OP_RTYPE, FN_SLTU, 0, 1, S_FETCH,   C_FETCH);
      add(OP_RTYPE, FN_SLTU, 0, 1, S_DECODE,  C_DECODE);
      add(OP_RTYPE, FN_SLTU, 0, 1, S_EXEC_R,  C_EX_SLTU);
      add(OP_RTYPE, FN_SLTU, 0, 1, S_WB_ALU,  C_WB_R);
      // ADDI
      add(OP_ADDI, 6'h15, 0, 1, S_FETCH,      C_FETCH);
      add(OP_ADDI, 6'h15, 0, 1, S_DECODE,     C_DECODE);
      add(OP_ADDI, 6'h15, 0, 1, S_EXEC_I,     C_EXEC_I);
      add(OP_ADDI, 6'h15, 0, 1, S_WB_ALU,     C_WB_I);
      // LW with three wait cycles in MEM_READ: 8 cycles total
      add(OP_LW, 6'h00, 0, 1, S_FETCH,        C_FETCH);
      add(OP_LW, 6'h00, 0, 1, S_DECODE,       C_DECODE);
      add(OP_LW, 6'h00, 0, 1, S_MEM_ADDR,     C_MEM_ADDR);
      add(OP_LW, 6'h00, 0, 0, S_MEM_READ,     C_MEM_READ);
      add(OP_LW, 6'h00, 0, 0, S_MEM_READ,     C_MEM_READ);
      add(OP_LW, 6'h00, 0, 0, S_MEM_READ,     C_MEM_READ);
      add(OP_LW, 6'h00, 0, 1, S_MEM_READ,     C_MEM_READ);
      add(OP_LW, 6'h00, 0, 1, S_WB_MEM,       C_WB_MEM);
      // SW zero-wait
      add(OP_SW, 6'h00, 0, 1, S_FETCH,        C_FETCH);
      add(OP_SW, 6'h00, 0, 1, S_DECODE,       C_DECODE);
      add(OP_SW, 6'h00, 0, 1, S_MEM_ADDR,     C_MEM_ADDR);
      add(OP_SW, 6'h00, 0, 1, S_MEM_WRITE,    C_MEM_WRITE);
      // BEQ taken, then not taken
      add(OP_BEQ, 6'h00, 1, 1, S_FETCH,       C_FETCH);
      add(OP_BEQ, 6'h00, 1, 1, S_DECODE,      C_DECODE);
      add(OP_BEQ, 6'h00, 1, 1, S_BRANCH,      C_BR_TAKEN);
      add(OP_BEQ, 6'h00, 0, 1, S_FETCH,       C_FETCH);
      add(OP_BEQ, 6'h00, 0, 1, S_DECODE,      C_DECODE);
      add(OP_BEQ, 6'h00, 0, 1, S_BRANCH,      C_BR_NOT);
      // Illegal opcode, then illegal R-type func (JR)
      add(6'b111111, 6'h00, 0, 1, S_FETCH,    C_FETCH);
      add(6'b111111, 6'h00, 0, 1, S_DECODE,   C_DEC_ILL);
      add(OP_RTYPE, 6'b001000, 0, 1, S_FETCH, C_FETCH);
      add(OP_RTYPE, 6'b001000, 0, 1, S_DECODE, C_DEC_ILL);
      // ADDIU with one fetch wait cycle
      add(OP_ADDIU, 6'h00, 0, 0, S_FETCH,     C_FETCH_W);
      add(OP_ADDIU, 6'h00, 0, 1, S_FETCH,     C_FETCH);
      add(OP_ADDIU, 6'h00, 0, 1, S_DECODE,    C_DECODE);
      add(OP_ADDIU, 6'h00, 0, 1, S_EXEC_I,    C_EXEC_I);
      add(OP_ADDIU, 6'h00, 0, 1, S_WB_ALU,    C_WB_I);

      // Reset state while held in reset
      #2;
      check("in_reset", S_IDLE, C_IDLE);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("in_reset_after_edges", S_IDLE, C_IDLE);
      rst_n = 1'b1;

      foreach (vecs[i])
         step($sformatf("vec%0d", i), vecs[i].op, vecs[i].fn, vecs[i].z,
              vecs[i].rdy, vecs[i].st, vecs[i].cw);

      // SW with reset asserted during the second MEM_WRITE wait cycle
      step("sw_fetch", OP_SW, 6'h00, 0, 1, S_FETCH,     C_FETCH);
      step("sw_dec",   OP_SW, 6'h00, 0, 1, S_DECODE,    C_DECODE);
      step("sw_addr",  OP_SW, 6'h00, 0, 1, S_MEM_ADDR,  C_MEM_ADDR);
      step("sw_wait1", OP_SW, 6'h00, 0, 0, S_MEM_WRITE, C_MEM_WRITE);
      #2;
      check("sw_wait2", S_MEM_WRITE, C_MEM_WRITE);
      rst_n = 1'b0;
      #1;
      check("sw_async_reset", S_IDLE, C_IDLE);
      @(posedge clk);
      #1;
      check("sw_reset_held", S_IDLE, C_IDLE);
      rst_n = 1'b1;
      step("rel_idle",   OP_RTYPE, FN_ADD, 0, 1, S_IDLE,   C_IDLE);
      step("rel_fetch",  OP_RTYPE, FN_ADD, 0, 1, S_FETCH,  C_FETCH);
      step("rel_decode", OP_RTYPE, FN_ADD, 0, 1, S_DECODE, C_DECODE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencing controller for the MIPS datapath. It replaces single-cycle decode with a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback. It shares one unified instruction/data memory through a req/ready handshake and drives every datapath mux, write enable and ALU operation per cycle. It supports the existing instruction set: ADD, ADDU, SUB, SUBU, AND, OR, SLL, SRL, SLT, SLTU, LW, SW, BEQ, ADDI and ADDIU.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op_code  in  6  IR[31:26]; valid from DECODE onward.
- func  in  6  IR[5:0]; valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write (SW), 0 = read.
- i_or_d  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load instruction register.
- pc_write  out  1  load PC.
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- reg_write  out  1  register-file write enable.
- reg_dst  out  1  destination: 1 = rd, 0 = rt.
- mem_to_reg  out  1  writeback source: 1 = MDR, 0 = ALUOut.
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = reg A.
- alu_src_b  out  2  ALU B input: 00 = reg B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- alu_op  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 sll, 101 srl, 110 slt, 111 sltu.
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode or func.
- state  out  4  current state, for debug.

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WRITE, WB_MEM, EXEC_R, EXEC_I, WB_ALU, BRANCH.
- IDLE: all outputs 0. Always goes to FETCH.
- FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000.
  - Holds while mem_ready=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut). Next state:
  - LW/SW → MEM_ADDR.
  - R-type with a legal func → EXEC_R.
  - ADDI/ADDIU → EXEC_I.
  - BEQ → BRANCH.
  - Anything else → FETCH with illegal_instr=1, and no write enable asserted.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000. Goes to MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: mem_req=1, i_or_d=1, mem_we=0. Holds until mem_ready, then WB_MEM.
- MEM_WRITE: mem_req=1, i_or_d=1, mem_we=1. Holds until mem_ready, then FETCH.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1, then FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op decoded from func (ADD/ADDU→000, SUB/SUBU→001, AND→010, OR→011, SLL→100, SRL→101, SLT→110, SLTU→111). Goes to WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=000. Goes to WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=0, reg_dst=1 if the instruction is R-type else 0. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_src=1, pc_write=zero. Goes to FETCH.
- Unlisted outputs are 0 in every state. No x values are driven on any output.

## Timing
- Outputs are combinational from state, except:
  - FETCH ir_write and pc_write depend on mem_ready.
  - BRANCH pc_write depends on zero.
- Handshake:
  - mem_req, mem_we and i_or_d stay stable until the cycle in which mem_ready=1. The transfer completes in that cycle.
  - mem_ready is ignored when mem_req=0.
  - Zero-wait memory (mem_ready high in the first request cycle) is legal.
- Cycles per instruction with zero-wait memory:
  - BEQ: 3.
  - R-type, ADDI/ADDIU, SW: 4.
  - LW: 5.
  - Illegal: 2.
  - Each memory wait cycle adds 1.
- Reset:
  - rst_n low forces state=IDLE asynchronously. All outputs go to 0 immediately, including mid-MEM_WRITE (mem_req drops).
  - The first FETCH occurs on the second rising edge after rst_n deasserts.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum (4-bit);
  - opcode constants (R-type 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, ADDIU 001001);
  - func constants;
  - alu_op codes;
  - alu_src_b encodings.
- Sub-module alu_func_decode is combinational: func → alu_op plus a legal flag. It is used in DECODE for the legality check and in EXEC_R for alu_op.

## Test plan
- Reset, then release with mem_ready=1 → cycle 1 IDLE with all outputs 0; cycle 2 FETCH with mem_req=1, ir_write=1, pc_write=1.
- ADD (op 000000, func 100000), zero-wait → FETCH, DECODE, EXEC_R (alu_op=000, alu_src_b=00), WB_ALU (reg_write=1, reg_dst=1); 4 cycles.
- LW with mem_ready held low for 3 cycles in MEM_READ → mem_req, i_or_d=1, mem_we=0 stable throughout; WB_MEM has mem_to_reg=1, reg_dst=0; total 8 cycles.
- BEQ with zero=1, then with zero=0 → BRANCH has pc_src=1 and pc_write=1 in the first case, pc_write=0 in the second; 3 cycles each.
- Opcode 111111 and R-type func 001000 → illegal_instr pulses once in DECODE; next state is FETCH; reg_write and mem_we are never asserted.
- SW, rst_n pulled low during the second MEM_WRITE wait cycle → mem_req and mem_we drop to 0 in the same cycle; state=IDLE; fetch resumes 2 edges after release.
